// File: rtl/aes_pkg.sv
// Shared AES types: byte/state containers, inverse S-box table and engine FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [7:0] byte_t;

    // Index 0 is the most significant byte, so state[i] == data[127-8i -: 8].
    typedef logic [0:15][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // AES inverse substitution table, row = high nibble, column = low nibble.
    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox.sv
// Single-byte AES inverse S-box lookup.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of a 128-bit block per cycle.
// Latency: out_valid rises 16/LANES cycles after the input handshake.
// Backpressure: result held in DONE until out_ready; in_ready low until the block leaves.
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NSTEP = 16 / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_e            state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_t          data_q, data_d;

    byte_t           sbox_in  [LANES];
    byte_t           sbox_out [LANES];
    logic [3:0]      lane_idx [LANES];

    // Each lane owns one byte of the current step's window: cnt*LANES + lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = 4'(int'(cnt_q) * LANES + g);
        assign sbox_in[g]  = data_q[lane_idx[g]];
        aes_inv_sbox u_sbox (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
        );
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    // Only a fully substituted block is ever exposed.
    assign out_data  = (state_q == DONE) ? 128'(data_q) : 128'h0;

    // Next-state, step counter and in-place byte substitution.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    data_d  = state_t'(in_data);
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[lane_idx[l]] = sbox_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed self-checking bench for aes_inv_sub_bytes at LANES = 4, 1 and 16.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_aes_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] out_data  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Forward AES S-box, used to build inputs whose inverse is known.
    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    aes_inv_sub_bytes #(.LANES(4)) dut_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );
    aes_inv_sub_bytes #(.LANES(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );
    aes_inv_sub_bytes #(.LANES(16)) dut_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
    );

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends one block from IDLE with out_ready high; returns result, latency and busy-cycle count.
    task automatic run_block(input int d, input logic [127:0] din,
                             output logic [127:0] dout, output int lat, output int bcyc);
        lat  = -1;
        bcyc = 0;
        dout = '0;
        in_data[d]   = din;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (out_valid[d]) begin
                lat  = c;
                dout = out_data[d];
                break;
            end
            if (busy[d]) bcyc++;
        end
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] res, blk, exp;
        int lat, bc, nin, nout, seen;
        int nst [3];
        int ocyc [2];
        logic [127:0] od [2];

        nst[0] = 4; nst[1] = 16; nst[2] = 1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
        end
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready[0], 0);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_out_data", out_data[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("post_rst_in_ready_d%0d", d), in_ready[d], 1);
        @(posedge clk); #1;

        // Single block, LANES=4
        run_block(0, 128'h637c777bf26b6fc53001672bfed7ab76, res, lat, bc);
        chk("single_data", res, 128'h000102030405060708090a0b0c0d0e0f);
        chk("single_latency", 128'(lat), 4);
        chk("single_busy_cycles", 128'(bc), 4);

        // Round trip over all 256 byte values on every lane configuration
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) begin
                for (int i = 0; i < 16; i++) begin
                    blk[127-8*i -: 8] = FWD[16*k+i];
                    exp[127-8*i -: 8] = 8'(16*k+i);
                end
                run_block(d, blk, res, lat, bc);
                chk($sformatf("roundtrip_d%0d_k%0d", d, k), res, exp);
                if (k == 0) begin
                    chk($sformatf("roundtrip_latency_d%0d", d), 128'(lat), 128'(nst[d]));
                    chk($sformatf("roundtrip_busy_d%0d", d), 128'(bc), 128'(nst[d]));
                end
            end
        end

        // Boundary bytes
        run_block(0, fill(8'h00), res, lat, bc);
        chk("all_00", res, fill(8'h52));
        run_block(0, fill(8'hff), res, lat, bc);
        chk("all_ff", res, fill(8'h7d));
        run_block(0, fill(8'h63), res, lat, bc);
        chk("all_63", res, fill(8'h00));

        // Backpressure: result held, second block refused
        in_data[0] = fill(8'h00); in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_data[0] = fill(8'hff);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin seen = 1; break; end
        end
        chk("bp_reached_done", 128'(seen), 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", c), out_valid[0], 1);
            chk($sformatf("bp_hold_data_%0d", c), out_data[0], fill(8'h52));
            chk($sformatf("bp_in_ready_%0d", c), in_ready[0], 0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid[0], 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        @(negedge clk);
        chk("bp_after_in_ready", in_ready[0], 1);
        chk("bp_after_out_valid", out_valid[0], 0);
        chk("bp_after_busy", busy[0], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_not_queued", busy[0], 0);
        @(posedge clk); #1;

        // Back-to-back streaming
        in_data[0] = fill(8'h52); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        nin = 0; nout = 0; ocyc[0] = -100; ocyc[1] = 0; od[0] = '0; od[1] = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) nin++;
            if (out_valid[0]) begin
                if (nout < 2) begin od[nout] = out_data[0]; ocyc[nout] = c; end
                nout++;
            end
            @(posedge clk); #1;
            if (nin == 1) in_data[0] = fill(8'h16);
            if (nin >= 2) in_valid[0] = 1'b0;
        end
        out_ready[0] = 1'b0;
        chk("stream_count", 128'(nout), 2);
        chk("stream_blk0", od[0], fill(8'h48));
        chk("stream_blk1", od[1], fill(8'hff));
        chk("stream_spacing", 128'(ocyc[1] - ocyc[0]), 6);

        // Reset during BUSY step 2
        in_data[0] = fill(8'h63); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy_before", busy[0], 1);
        chk("midrst_in_ready_during", in_ready[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_in_ready", in_ready[0], 1);
        out_ready[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid[0] || busy[0]) seen++;
        end
        chk("midrst_no_stale", 128'(seen), 0);
        @(posedge clk); #1;
        run_block(0, 128'h637c777bf26b6fc53001672bfed7ab76, res, lat, bc);
        chk("midrst_recover", res, 128'h000102030405060708090a0b0c0d0e0f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
